// File: rtl/iw_writeback_regfile.sv
// Writeback stage: selects result and destination, commits into a 32x32 register file,
// and keeps a per-register pending-write scoreboard for decode issue control.
module iw_writeback_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wb_pc,
  input  logic [DATA_W-1:0] wb_O,
  input  logic [DATA_W-1:0] wb_D,
  input  logic              wb_res_data_sel,
  input  logic              wb_write_to_reg,
  input  logic              wb_dest_reg_sel,
  input  logic [4:0]        wb_rt,
  input  logic [4:0]        wb_rd,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              issue_valid,
  input  logic [4:0]        issue_dest,
  output logic              issue_ready,
  output logic [4:0]        wb_dest,
  output logic [31:0]       retire_count,
  output logic [DATA_W-1:0] last_wb_pc,
  output logic              sb_underflow
);

  localparam logic [PEND_W-1:0] PendMax = '1;
  localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [PEND_W-1:0] pend_q [NREGS];
  logic [PEND_W-1:0] pend_d [NREGS];
  logic [31:0]       retire_q;
  logic [DATA_W-1:0] last_pc_q;
  logic              underflow_q, underflow_d;

  logic [4:0]        dest;
  logic [DATA_W-1:0] wdata;
  logic              commit;
  logic              inc;

  assign dest   = wb_dest_reg_sel ? wb_rd : wb_rt;
  assign wdata  = wb_res_data_sel ? wb_D : wb_O;
  assign commit = wb_write_to_reg && (dest != 5'd0);

  // A commit to the issuing register frees a slot in the same cycle.
  assign issue_ready = !((pend_q[issue_dest] == PendMax) && !(commit && (dest == issue_dest)));
  assign inc         = issue_valid && issue_ready && (issue_dest != 5'd0);

  assign rs_data = (rs_addr == 5'd0) ? '0 :
                   (commit && (dest == rs_addr)) ? wdata : regs_q[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? '0 :
                   (commit && (dest == rt_addr)) ? wdata : regs_q[rt_addr];

  assign rs_busy = (rs_addr != 5'd0) && (pend_q[rs_addr] != '0) &&
                   !((pend_q[rs_addr] == PendOne) && commit && (dest == rs_addr));
  assign rt_busy = (rt_addr != 5'd0) && (pend_q[rt_addr] != '0) &&
                   !((pend_q[rt_addr] == PendOne) && commit && (dest == rt_addr));

  assign wb_dest      = dest;
  assign retire_count = retire_q;
  assign last_wb_pc   = last_pc_q;
  assign sb_underflow = underflow_q;

  always_comb begin
    pend_d      = pend_q;
    underflow_d = underflow_q;
    if (commit && (pend_q[dest] == '0)) begin
      underflow_d = 1'b1;
    end
    for (int i = 1; i < NREGS; i++) begin
      if (commit && (dest == 5'(i))) begin
        // Underflowing commit leaves the count at 0, so a same-cycle issue lands at 1.
        if (pend_q[i] == '0) begin
          pend_d[i] = (inc && (issue_dest == 5'(i))) ? PendOne : '0;
        end else if (!(inc && (issue_dest == 5'(i)))) begin
          pend_d[i] = pend_q[i] - PendOne;
        end
      end else if (inc && (issue_dest == 5'(i))) begin
        pend_d[i] = pend_q[i] + PendOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
        pend_q[i] <= '0;
      end
      retire_q    <= '0;
      last_pc_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (commit) begin
        regs_q[dest] <= wdata;
        retire_q     <= retire_q + 32'd1;
        last_pc_q    <= wb_pc;
      end
      for (int i = 0; i < NREGS; i++) begin
        pend_q[i] <= pend_d[i];
      end
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_iw_writeback_regfile.sv
// Bench for iw_writeback_regfile: directed scenarios then random traffic, all checked
// against an array/counter reference model.
module tb_iw_writeback_regfile;

  localparam int PendMax = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wb_pc, wb_O, wb_D;
  logic        wb_res_data_sel, wb_write_to_reg, wb_dest_reg_sel;
  logic [4:0]  wb_rt, wb_rd, rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic        rs_busy, rt_busy;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic        issue_ready;
  logic [4:0]  wb_dest;
  logic [31:0] retire_count, last_wb_pc;
  logic        sb_underflow;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] mregs [32];
  int          mpend [32];
  logic        munder;
  logic [31:0] mretire;
  logic [31:0] mlastpc;

  always #5 clk = ~clk;

  iw_writeback_regfile dut (
    .clk(clk), .rst_n(rst_n), .wb_pc(wb_pc), .wb_O(wb_O), .wb_D(wb_D),
    .wb_res_data_sel(wb_res_data_sel), .wb_write_to_reg(wb_write_to_reg),
    .wb_dest_reg_sel(wb_dest_reg_sel), .wb_rt(wb_rt), .wb_rd(wb_rd),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .issue_valid(issue_valid),
    .issue_dest(issue_dest), .issue_ready(issue_ready), .wb_dest(wb_dest),
    .retire_count(retire_count), .last_wb_pc(last_wb_pc), .sb_underflow(sb_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      mpend[i] = 0;
    end
    munder  = 1'b0;
    mretire = '0;
    mlastpc = '0;
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a, input logic cm,
                                           input logic [4:0] d, input logic [31:0] wd);
    if (a == 0) return '0;
    if (cm && d == a) return wd;
    return mregs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input logic cm, input logic [4:0] d);
    if (a == 0 || mpend[a] == 0) return 1'b0;
    return !(mpend[a] == 1 && cm && d == a);
  endfunction

  task automatic set_wb(input logic we, input logic dsel, input logic [4:0] rt,
                        input logic [4:0] rd, input logic rsel, input logic [31:0] o,
                        input logic [31:0] dd, input logic [31:0] pc);
    wb_write_to_reg = we; wb_dest_reg_sel = dsel; wb_rt = rt; wb_rd = rd;
    wb_res_data_sel = rsel; wb_O = o; wb_D = dd; wb_pc = pc;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] d);
    issue_valid = v; issue_dest = d;
  endtask

  task automatic idle();
    set_wb(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    set_issue(1'b0, 5'd0);
  endtask

  // Inputs are already applied (just after a falling edge); check, then clock once.
  task automatic cycle();
    logic [4:0]  d;
    logic [31:0] wd;
    logic        cm, rdy, acc;
    #1;
    d   = wb_dest_reg_sel ? wb_rd : wb_rt;
    wd  = wb_res_data_sel ? wb_D : wb_O;
    cm  = wb_write_to_reg && d != 0;
    rdy = !(issue_dest != 0 && mpend[issue_dest] == PendMax && !(cm && d == issue_dest));
    acc = issue_valid && rdy && issue_dest != 0;
    check("wb_dest", 32'(wb_dest), 32'(d));
    check("rs_data", rs_data, exp_data(rs_addr, cm, d, wd));
    check("rt_data", rt_data, exp_data(rt_addr, cm, d, wd));
    check("rs_busy", 32'(rs_busy), 32'(exp_busy(rs_addr, cm, d)));
    check("rt_busy", 32'(rt_busy), 32'(exp_busy(rt_addr, cm, d)));
    check("issue_ready", 32'(issue_ready), 32'(rdy));
    // Sequential view: retire the commit first, then account for the issue.
    if (cm) begin
      mregs[d] = wd;
      mretire  = mretire + 1;
      mlastpc  = wb_pc;
      if (mpend[d] == 0) munder = 1'b1;
      else mpend[d] = mpend[d] - 1;
    end
    if (acc) mpend[issue_dest] = mpend[issue_dest] + 1;
    @(posedge clk);
    #1;
    check("retire_count", retire_count, mretire);
    check("last_wb_pc", last_wb_pc, mlastpc);
    check("sb_underflow", 32'(sb_underflow), 32'(munder));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Read every address after reset.
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a);
      rt_addr = 5'(31 - a);
      cycle();
    end
    check("reset_retire", retire_count, 32'd0);

    // Issue r5, wait a cycle, then commit through rd with the ALU result.
    rs_addr = 5'd5; rt_addr = 5'd9;
    set_issue(1'b1, 5'd5);
    cycle();
    set_issue(1'b0, 5'd0);
    cycle();
    check("r5_busy_pending", 32'(rs_busy), 32'd1);
    set_wb(1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 32'hDEADBEEF, 32'h0, 32'h40);
    #1;
    check("r5_bypass", rs_data, 32'hDEADBEEF);
    check("r5_busy_commit", 32'(rs_busy), 32'd0);
    cycle();
    idle();
    cycle();
    check("r5_array", rs_data, 32'hDEADBEEF);
    check("r5_retire", retire_count, 32'd1);
    check("r5_pc", last_wb_pc, 32'h40);

    // Commit via rt with load data; rd must stay untouched. Then a write to r0.
    rs_addr = 5'd7; rt_addr = 5'd9;
    set_issue(1'b1, 5'd7);
    cycle();
    set_issue(1'b0, 5'd0);
    set_wb(1'b1, 1'b0, 5'd7, 5'd9, 1'b1, 32'hFFFF0000, 32'h1234, 32'h44);
    cycle();
    set_wb(1'b1, 1'b1, 5'd7, 5'd0, 1'b0, 32'hCAFEF00D, 32'h0, 32'h48);
    rs_addr = 5'd0;
    cycle();
    idle();
    rs_addr = 5'd7;
    cycle();
    check("r7_value", rs_data, 32'h1234);
    check("r9_untouched", rt_data, 32'h0);
    check("r0_no_retire", retire_count, 32'd2);

    // Saturate r3, bounce the fourth issue, then commit+issue together and drain.
    rs_addr = 5'd3; rt_addr = 5'd3;
    repeat (3) begin
      set_issue(1'b1, 5'd3);
      cycle();
    end
    #1;
    check("r3_full_ready", 32'(issue_ready), 32'd0);
    cycle();
    set_wb(1'b1, 1'b1, 5'd0, 5'd3, 1'b0, 32'h33, 32'h0, 32'h50);
    #1;
    check("r3_commit_ready", 32'(issue_ready), 32'd1);
    cycle();
    set_issue(1'b0, 5'd0);
    for (int k = 0; k < 3; k++) begin
      set_wb(1'b1, 1'b1, 5'd0, 5'd3, 1'b1, 32'h0, 32'h300 + 32'(k), 32'h54 + 32'(4 * k));
      cycle();
    end
    idle();
    cycle();
    check("r3_drained", 32'(rs_busy), 32'd0);
    check("no_underflow_yet", 32'(sb_underflow), 32'd0);

    // Commit to r10 without an issue: written, underflow sticks.
    rs_addr = 5'd10;
    set_wb(1'b1, 1'b0, 5'd10, 5'd0, 1'b0, 32'hA5A5A5A5, 32'h0, 32'h70);
    cycle();
    set_wb(1'b1, 1'b1, 5'd0, 5'd3, 1'b0, 32'h1, 32'h0, 32'h74);
    set_issue(1'b1, 5'd3);
    cycle();
    idle();
    cycle();
    check("r10_value", rs_data, 32'hA5A5A5A5);
    check("underflow_sticky", 32'(sb_underflow), 32'd1);

    // Reset between an issue and its commit.
    rs_addr = 5'd12; rt_addr = 5'd10;
    set_issue(1'b1, 5'd12);
    cycle();
    idle();
    rst_n = 1'b0;
    model_clear();
    #1;
    check("rst_busy", 32'(rs_busy), 32'd0);
    check("rst_ready", 32'(issue_ready), 32'd1);
    check("rst_regs", rt_data, 32'd0);
    check("rst_underflow", 32'(sb_underflow), 32'd0);
    check("rst_retire", retire_count, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_wb(1'b1, 1'b1, 5'd0, 5'd12, 1'b0, 32'h12, 32'h0, 32'h80);
    cycle();
    check("post_rst_underflow", 32'(sb_underflow), 32'd1);

    // Random traffic over a small register window to exercise saturation and bypass.
    for (int n = 0; n < 400; n++) begin
      set_wb(1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom), $urandom, $urandom, $urandom);
      set_issue(1'($urandom), 5'($urandom_range(0, 7)));
      rs_addr = 5'($urandom_range(0, 7));
      rt_addr = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
